// File: rtl/booth_seq_multiplier_if.sv
// Operand/result handshake bundle for booth_seq_multiplier.
// The master supplies operands and start; the slave reports busy, done and the product.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock.
// Unsigned operation adds one zero-extension bit so the signed recoding stays exact.
module booth_seq_multiplier #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_seq_multiplier_if.slave  bus
);
    localparam int N  = SIGNED ? WIDTH : WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N:0]         a_q, a_d;
    logic [N:0]         m_q, m_d;
    logic [N-1:0]       q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [N:0]         mExt;
    logic [N-1:0]       qExt;
    logic [N:0]         sum;
    logic [N:0]         aShift;
    logic [N-1:0]       qShift;
    logic [2*WIDTH-1:0] prodStep;

    // The guard bit on A and M keeps A-M in range even for the most-negative multiplicand.
    generate
        if (SIGNED) begin : g_signed
            assign mExt     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
            assign qExt     = bus.multiplier;
            assign prodStep = {aShift[WIDTH-1:0], qShift};
        end else begin : g_unsigned
            assign mExt     = {2'b00, bus.multiplicand};
            assign qExt     = {1'b0, bus.multiplier};
            assign prodStep = {aShift[WIDTH-2:0], qShift};
        end
    endgenerate

    always_comb begin
        sum = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        aShift = {sum[N], sum[N:1]};
        qShift = {sum[0], q_q[N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = '0;
                    m_d     = mExt;
                    q_d     = qExt;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = aShift;
                q_d   = qShift;
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    prod_d  = prodStep;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: 8-bit signed, 8-bit unsigned and 4-bit signed instances
// checked each cycle against a latency/arithmetic model, plus directed literal vectors.
module tb_booth_seq_multiplier;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    logic       stIn [3];
    logic [7:0] mIn  [3];
    logic [7:0] qIn  [3];

    logic        actBusy [3];
    logic        actDone [3];
    logic [15:0] actProd [3];

    int total = 0;
    int bad   = 0;

    booth_seq_multiplier_if #(.WIDTH(8)) if8s ();
    booth_seq_multiplier_if #(.WIDTH(8)) if8u ();
    booth_seq_multiplier_if #(.WIDTH(4)) if4s ();

    booth_seq_multiplier #(.WIDTH(8), .SIGNED(1'b1)) dut8s (.clk(clk), .rst_n(rst_n), .bus(if8s));
    booth_seq_multiplier #(.WIDTH(8), .SIGNED(1'b0)) dut8u (.clk(clk), .rst_n(rst_n), .bus(if8u));
    booth_seq_multiplier #(.WIDTH(4), .SIGNED(1'b1)) dut4s (.clk(clk), .rst_n(rst_n), .bus(if4s));

    assign if8s.start        = stIn[0];
    assign if8s.multiplicand = mIn[0];
    assign if8s.multiplier   = qIn[0];
    assign if8u.start        = stIn[1];
    assign if8u.multiplicand = mIn[1];
    assign if8u.multiplier   = qIn[1];
    assign if4s.start        = stIn[2];
    assign if4s.multiplicand = mIn[2][3:0];
    assign if4s.multiplier   = qIn[2][3:0];

    assign actBusy[0] = if8s.busy;
    assign actBusy[1] = if8u.busy;
    assign actBusy[2] = if4s.busy;
    assign actDone[0] = if8s.done;
    assign actDone[1] = if8u.done;
    assign actDone[2] = if4s.done;
    assign actProd[0] = if8s.product;
    assign actProd[1] = if8u.product;
    assign actProd[2] = {8'h00, if4s.product};

    // Exact product of the operands as each instance interprets them.
    function automatic logic [15:0] refMul(int idx, logic [7:0] m, logic [7:0] q);
        longint a;
        longint b;
        longint p;
        if (idx == 0) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else if (idx == 1) begin
            a = longint'(m);
            b = longint'(q);
        end else begin
            a = longint'($signed(m[3:0]));
            b = longint'($signed(q[3:0]));
        end
        p = a * b;
        if (idx == 2) return {8'h00, p[7:0]};
        return p[15:0];
    endfunction

    function automatic int nSteps(int idx);
        if (idx == 0) return 8;
        if (idx == 1) return 9;
        return 4;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a start seen while not busy captures the exact product, which appears
    // together with a single done pulse after the instance's step count has elapsed.
    logic        eBusy [3];
    logic        eDone [3];
    logic [15:0] eProd [3];
    logic [15:0] pend  [3];
    int          rem   [3];
    int          doneSeen [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                eBusy[i] <= 1'b0;
                eDone[i] <= 1'b0;
                eProd[i] <= 16'h0000;
                pend[i]  <= 16'h0000;
                rem[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                eDone[i] <= 1'b0;
                if (eBusy[i]) begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        eBusy[i] <= 1'b0;
                        eDone[i] <= 1'b1;
                        eProd[i] <= pend[i];
                    end
                end else if (stIn[i]) begin
                    eBusy[i] <= 1'b1;
                    rem[i]   <= nSteps(i);
                    pend[i]  <= refMul(i, mIn[i], qIn[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && armed) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("busy%0d", i), 32'(actBusy[i]), 32'(eBusy[i]));
                checkOutput($sformatf("done%0d", i), 32'(actDone[i]), 32'(eDone[i]));
                checkOutput($sformatf("prod%0d", i), 32'(actProd[i]), 32'(eProd[i]));
                doneSeen[i] <= doneSeen[i] + int'(actDone[i]);
            end
        end
    end

    task automatic applyStimulus(int idx, logic [7:0] m, logic [7:0] q);
        stIn[idx] = 1'b1;
        mIn[idx]  = m;
        qIn[idx]  = q;
        @(negedge clk);
        stIn[idx] = 1'b0;
    endtask

    task automatic waitDone(int idx, output int lat, output logic [15:0] prod);
        lat = 0;
        while (!actDone[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        prod = actProd[idx];
    endtask

    int          lat;
    int          d0;
    int          cnt;
    logic [15:0] prod;
    logic [7:0]  pv;

    initial begin
        for (int i = 0; i < 3; i++) begin
            stIn[i]     = 1'b0;
            mIn[i]      = 8'h00;
            qIn[i]      = 8'h00;
            doneSeen[i] = 0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b1;

        checkOutput("rst_busy", 32'(actBusy[0]), 32'h0);
        checkOutput("rst_done", 32'(actDone[0]), 32'h0);
        checkOutput("rst_prod", 32'(actProd[0]), 32'h0);
        checkOutput("model_7xm3", 32'(refMul(0, 8'h07, 8'hFD)), 32'hFFEB);
        checkOutput("model_u255", 32'(refMul(1, 8'hFF, 8'hFF)), 32'hFE01);
        checkOutput("model_4m8m8", 32'(refMul(2, 8'h08, 8'h08)), 32'h0040);

        applyStimulus(0, 8'h07, 8'hFD);
        waitDone(0, lat, prod);
        checkOutput("lat_7xm3", 32'(lat), 32'd8);
        checkOutput("prod_7xm3", 32'(prod), 32'hFFEB);

        applyStimulus(0, 8'h80, 8'h80);
        waitDone(0, lat, prod);
        checkOutput("prod_m128sq", 32'(prod), 32'h4000);

        applyStimulus(0, 8'h80, 8'h01);
        waitDone(0, lat, prod);
        checkOutput("prod_m128x1", 32'(prod), 32'hFF80);

        applyStimulus(1, 8'hFF, 8'hFF);
        waitDone(1, lat, prod);
        checkOutput("lat_u255", 32'(lat), 32'd9);
        checkOutput("prod_u255", 32'(prod), 32'hFE01);

        // A start raised three cycles into RUN must be dropped entirely.
        repeat (3) @(negedge clk);
        d0 = doneSeen[0];
        applyStimulus(0, 8'h05, 8'h06);
        repeat (2) @(negedge clk);
        stIn[0] = 1'b1;
        mIn[0]  = 8'h64;
        qIn[0]  = 8'h64;
        @(negedge clk);
        stIn[0] = 1'b0;
        waitDone(0, lat, prod);
        checkOutput("prod_ignore", 32'(prod), 32'h001E);
        repeat (14) @(negedge clk);
        checkOutput("dones_ignore", 32'(doneSeen[0] - d0), 32'd1);

        // Every 4-bit signed pair with start held high, so each DONE reloads at once.
        d0 = doneSeen[2];
        for (int p = 0; p < 256; p++) begin
            pv      = 8'(p);
            mIn[2]  = {4'h0, pv[7:4]};
            qIn[2]  = {4'h0, pv[3:0]};
            stIn[2] = 1'b1;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!actDone[2] && cnt < 20);
            checkOutput($sformatf("period4_%0d", p), 32'(cnt), 32'd5);
        end
        stIn[2] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("dones_exh", 32'(doneSeen[2] - d0), 32'd256);

        // Asynchronous reset between clock edges in the middle of an operation.
        applyStimulus(0, 8'h9C, 8'h9C);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(actBusy[0]), 32'h0);
        checkOutput("arst_done", 32'(actDone[0]), 32'h0);
        checkOutput("arst_prod", 32'(actProd[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h0C, 8'hF5);
        waitDone(0, lat, prod);
        checkOutput("lat_after_rst", 32'(lat), 32'd8);
        checkOutput("prod_after_rst", 32'(prod), 32'hFF7C);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
